pakout_rr_arb: RTL and testbench

- Round-robin scheduler that shares one packet-output link between NUM_SRC packet sources, for example several pakout instances feeding one pakout_io sink.
- Each packet is one {address, data} word and is forwarded atomically through a single-entry holding register.
- Packets whose address falls outside [MIN_ADDR, MAX_ADDR] are consumed and dropped, and the first offender is latched for debug display.

---
 rtl/pakout_rr_arb_pkg.sv | 12 +
 rtl/pakout_rr_arb_rr_pick.sv | 29 ++
 rtl/pakout_rr_arb.sv | 157 +++++++++++++++
 tb/tb_pakout_rr_arb.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pakout_rr_arb_pkg.sv
// Shared sizes and state encodings for the packet-output round-robin arbiter.
// The pick logic is generic, so future sink-side demux schedulers can reuse it.
package pakout_rr_arb_pkg;

  localparam int NS_ADDRESS_SIZE = 6;
  localparam int NS_DATA_SIZE    = 4;
  localparam int NS_PACKET_SIZE  = NS_ADDRESS_SIZE + NS_DATA_SIZE;

  localparam logic [0:0] NS_ARB_IDLE = 1'b0;
  localparam logic [0:0] NS_ARB_SEND = 1'b1;

endpackage

// File: rtl/pakout_rr_arb_rr_pick.sv
// Combinational round-robin selector: the first set bit of pend_i at or after
// (ptr_i+1) mod N, wrapping around.
module pakout_rr_arb_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  pend_i,
  input  logic [IW-1:0] ptr_i,
  output logic          any_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand;

  // Walk from the farthest offset down so the nearest pending source wins.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int off = N; off >= 1; off--) begin
      cand = IW'((int'(ptr_i) + off) % N);
      if (pend_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/pakout_rr_arb.sv
// Round-robin scheduler sharing one two-phase toggle packet link between
// NUM_SRC sources; out-of-range packets are dropped and the first is latched.
module pakout_rr_arb
  import pakout_rr_arb_pkg::*;
#(
  parameter int NUM_SRC  = 4,
  parameter int ASZ      = NS_ADDRESS_SIZE,
  parameter int DSZ      = NS_DATA_SIZE,
  parameter int MIN_ADDR = 0,
  parameter int MAX_ADDR = 55,
  parameter int CSZ      = 8,
  localparam int PSZ     = ASZ + DSZ,
  localparam int SW      = $clog2(NUM_SRC)
) (
  input  logic                   i_clk,
  input  logic                   reset,
  output logic                   ready,
  input  logic [NUM_SRC-1:0]     i_req,
  output logic [NUM_SRC-1:0]     i_ack,
  input  logic [NUM_SRC*PSZ-1:0] i_pak,
  output logic                   o_req,
  input  logic                   o_ack,
  output logic [PSZ-1:0]         o_pak,
  output logic [SW-1:0]          o_src,
  output logic                   o_err,
  output logic [ASZ-1:0]         fst_err_addr,
  output logic [SW-1:0]          fst_err_src,
  output logic [CSZ-1:0]         o_cnt,
  output logic [0:0]             o_dbg_state
);

  // Toggle handshake on every channel: a channel is pending while req != ack;
  // the producer holds its packet stable until the consumer toggles ack.

  localparam logic [ASZ-1:0] MIN_A = ASZ'(MIN_ADDR);
  localparam logic [ASZ-1:0] MAX_A = ASZ'(MAX_ADDR);

  logic [0:0]         state_q, state_d;
  logic [SW-1:0]      ptr_q, ptr_d;
  logic [NUM_SRC-1:0] ack_q, ack_d;
  logic               oreq_q, oreq_d;
  logic [PSZ-1:0]     pak_q, pak_d;
  logic [SW-1:0]      src_q, src_d;
  logic               err_q, err_d;
  logic [ASZ-1:0]     eaddr_q, eaddr_d;
  logic [SW-1:0]      esrc_q, esrc_d;
  logic [CSZ-1:0]     cnt_q, cnt_d;
  logic               ready_q;

  logic [NUM_SRC-1:0] pend;
  logic               pick_any;
  logic [SW-1:0]      pick_idx;
  logic [PSZ-1:0]     sel_pak;
  logic [ASZ-1:0]     sel_addr;
  logic [ASZ:0]       lo_diff, hi_diff;
  logic               addr_ok;

  assign pend = i_req ^ ack_q;

  pakout_rr_arb_rr_pick #(
    .N  (NUM_SRC),
    .IW (SW)
  ) u_pick (
    .pend_i (pend),
    .ptr_i  (ptr_q),
    .any_o  (pick_any),
    .idx_o  (pick_idx)
  );

  always_comb begin
    sel_pak = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (pick_idx == SW'(k)) sel_pak = i_pak[k*PSZ +: PSZ];
    end
  end

  // Unsigned range check via borrow bits, so a zero MIN_ADDR needs no special case.
  assign sel_addr = sel_pak[PSZ-1 -: ASZ];
  assign lo_diff  = {1'b0, sel_addr} - {1'b0, MIN_A};
  assign hi_diff  = {1'b0, MAX_A} - {1'b0, sel_addr};
  assign addr_ok  = !lo_diff[ASZ] && !hi_diff[ASZ];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ack_d   = ack_q;
    oreq_d  = oreq_q;
    pak_d   = pak_q;
    src_d   = src_q;
    err_d   = err_q;
    eaddr_d = eaddr_q;
    esrc_d  = esrc_q;
    cnt_d   = cnt_q;
    case (state_q)
      NS_ARB_IDLE: begin
        if (pick_any) begin
          ack_d[pick_idx] = ~ack_q[pick_idx];
          ptr_d           = pick_idx;
          if (addr_ok) begin
            pak_d   = sel_pak;
            src_d   = pick_idx;
            oreq_d  = ~oreq_q;
            cnt_d   = cnt_q + CSZ'(1);
            state_d = NS_ARB_SEND;
          end else if (!err_q) begin
            err_d   = 1'b1;
            eaddr_d = sel_addr;
            esrc_d  = pick_idx;
          end
        end
      end
      default: begin
        if (o_ack == oreq_q) state_d = NS_ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state_q <= NS_ARB_IDLE;
      ptr_q   <= SW'(NUM_SRC - 1);
      ack_q   <= '0;
      oreq_q  <= 1'b0;
      pak_q   <= '0;
      src_q   <= '0;
      err_q   <= 1'b0;
      eaddr_q <= '0;
      esrc_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      oreq_q  <= oreq_d;
      pak_q   <= pak_d;
      src_q   <= src_d;
      err_q   <= err_d;
      eaddr_q <= eaddr_d;
      esrc_q  <= esrc_d;
      cnt_q   <= cnt_d;
      ready_q <= 1'b1;
    end
  end

  assign ready        = ready_q;
  assign i_ack        = ack_q;
  assign o_req        = oreq_q;
  assign o_pak        = pak_q;
  assign o_src        = src_q;
  assign o_err        = err_q;
  assign fst_err_addr = eaddr_q;
  assign fst_err_src  = esrc_q;
  assign o_cnt        = cnt_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_pakout_rr_arb.sv
// Directed bench for pakout_rr_arb: reset, single packets, round-robin order,
// sink stall, out-of-range drops, counter wrap and reset in the middle of a send.
module tb_pakout_rr_arb;

  localparam int N   = 4;
  localparam int ASZ = 6;
  localparam int DSZ = 4;
  localparam int PSZ = ASZ + DSZ;
  localparam int CSZ = 8;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             ready;
  logic [N-1:0]     req;
  logic [N-1:0]     i_ack;
  logic [N*PSZ-1:0] pak;
  logic             o_req;
  logic             o_ack;
  logic [PSZ-1:0]   o_pak;
  logic [1:0]       o_src;
  logic             o_err;
  logic [ASZ-1:0]   fea;
  logic [1:0]       fes;
  logic [CSZ-1:0]   o_cnt;
  logic [0:0]       dbg;

  pakout_rr_arb dut (
    .i_clk        (clk),
    .reset        (rst_n),
    .ready        (ready),
    .i_req        (req),
    .i_ack        (i_ack),
    .i_pak        (pak),
    .o_req        (o_req),
    .o_ack        (o_ack),
    .o_pak        (o_pak),
    .o_src        (o_src),
    .o_err        (o_err),
    .fst_err_addr (fea),
    .fst_err_src  (fes),
    .o_cnt        (o_cnt),
    .o_dbg_state  (dbg)
  );

  // ---------------- scoreboard state ----------------
  int             total = 0;
  int             bad   = 0;
  logic [1:0]     exp_q[$];
  logic [CSZ-1:0] exp_cnt;
  logic           oreq_seen;
  logic [N-1:0]   src_auto;
  logic           sink_auto;
  logic [N-1:0]   ack_exp;
  logic [1:0]     e_src;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic refill();
    for (int k = 0; k < N; k++) begin
      if (src_auto[k] && (req[k] == i_ack[k])) begin
        pak[k*PSZ +: PSZ] = {ASZ'(k * 8 + 1), DSZ'(k)};
        req[k] = ~req[k];
      end
    end
  endtask

  // One clock: sample point is the falling edge, then sink and sources react.
  task automatic step();
    @(negedge clk);
    if (sink_auto) o_ack = o_req;
    refill();
  endtask

  task automatic send(input int k, input logic [ASZ-1:0] a, input logic [DSZ-1:0] d);
    pak[k*PSZ +: PSZ] = {a, d};
    req[k] = ~req[k];
  endtask

  task automatic wait_grant(input string tag, input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (o_req !== oreq_seen) begin
        got       = 1'b1;
        oreq_seen = o_req;
      end
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n     = 1'b0;
    req       = '0;
    pak       = '0;
    o_ack     = 1'b0;
    src_auto  = '0;
    sink_auto = 1'b0;
    oreq_seen = 1'b0;
    exp_cnt   = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_oreq",  32'(o_req), 32'd0);
    chk("rst_ack",   32'(i_ack), 32'd0);
    chk("rst_cnt",   32'(o_cnt), 32'd0);
    chk("rst_err",   32'(o_err), 32'd0);
    chk("rst_state", 32'(dbg),   32'(ST_IDLE));

    rst_n = 1'b1;
    step();
    chk("rel_ready", 32'(ready), 32'd1);

    // All four continuously pending: strict 0,1,2,3 rotation from reset.
    src_auto  = 4'hF;
    sink_auto = 1'b1;
    refill();
    for (int i = 0; i < 12; i++) exp_q.push_back(2'(i % 4));
    for (int i = 0; i < 12; i++) begin
      wait_grant("rr_grant", 4);
      exp_cnt = exp_cnt + 1'b1;
      e_src   = exp_q.pop_front();
      chk("rr_src", 32'(o_src), 32'(e_src));
      chk("rr_cnt", 32'(o_cnt), 32'(exp_cnt));
      if (i == 7) src_auto = '0;
    end
    step();
    chk("rr_idle",    32'(dbg),   32'(ST_IDLE));
    chk("rr_drained", 32'(i_ack), 32'(req));

    // Sink stall: ptr ends at 1, then sources 1 and 3 wait behind a held send.
    sink_auto = 1'b0;
    send(1, 6'd30, 4'd2);
    wait_grant("st_first", 1);
    exp_cnt = exp_cnt + 1'b1;
    chk("st_first_src", 32'(o_src), 32'd1);
    ack_exp = req;
    send(3, 6'd44, 4'd3);
    send(1, 6'd31, 4'd5);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("st_ack_hold",  32'(i_ack), 32'(ack_exp));
      chk("st_oreq_hold", 32'(o_req), 32'(oreq_seen));
      chk("st_state",     32'(dbg),   32'(ST_SEND));
    end
    o_ack = oreq_seen;
    wait_grant("st_next", 3);
    exp_cnt = exp_cnt + 1'b1;
    chk("st_next_src", 32'(o_src), 32'd3);
    chk("st_next_pak", 32'(o_pak), 32'({6'd44, 4'd3}));
    sink_auto = 1'b1;
    wait_grant("st_last", 4);
    exp_cnt = exp_cnt + 1'b1;
    chk("st_last_src", 32'(o_src), 32'd1);
    chk("st_last_pak", 32'(o_pak), 32'({6'd31, 4'd5}));
    chk("st_cnt",      32'(o_cnt), 32'(exp_cnt));
    step();

    // Out-of-range drops: consumed, no forward, only the first one latched.
    send(0, 6'd60, 4'd1);
    step();
    chk("drop0_ack",   32'(i_ack), 32'(req));
    chk("drop0_oreq",  32'(o_req), 32'(oreq_seen));
    chk("drop0_err",   32'(o_err), 32'd1);
    chk("drop0_addr",  32'(fea),   32'd60);
    chk("drop0_src",   32'(fes),   32'd0);
    chk("drop0_cnt",   32'(o_cnt), 32'(exp_cnt));
    chk("drop0_state", 32'(dbg),   32'(ST_IDLE));
    send(1, 6'd58, 4'd2);
    step();
    chk("drop1_ack",  32'(i_ack), 32'(req));
    chk("drop1_oreq", 32'(o_req), 32'(oreq_seen));
    chk("drop1_err",  32'(o_err), 32'd1);
    chk("drop1_addr", 32'(fea),   32'd60);
    chk("drop1_src",  32'(fes),   32'd0);
    chk("drop1_cnt",  32'(o_cnt), 32'(exp_cnt));

    // Single source 2, addr 23 data 7: forwarded one cycle after going pending.
    send(2, 6'd23, 4'd7);
    wait_grant("s2_grant", 1);
    exp_cnt = exp_cnt + 1'b1;
    chk("s2_pak",   32'(o_pak), 32'h177);
    chk("s2_src",   32'(o_src), 32'd2);
    chk("s2_ack",   32'(i_ack), 32'(req));
    chk("s2_cnt",   32'(o_cnt), 32'd16);
    chk("s2_state", 32'(dbg),   32'(ST_SEND));
    step();

    // Counter wrap: run to 255, then one more forward.
    src_auto = 4'b0001;
    refill();
    for (int i = 0; i < 239; i++) begin
      wait_grant("wr_grant", 4);
      exp_cnt = exp_cnt + 1'b1;
      chk("wr_cnt", 32'(o_cnt), 32'(exp_cnt));
    end
    chk("wr_at_max", 32'(o_cnt), 32'd255);
    src_auto = '0;
    wait_grant("wr_last", 4);
    chk("wr_zero", 32'(o_cnt), 32'd0);
    chk("wr_src",  32'(o_src), 32'd0);
    chk("wr_pak",  32'(o_pak), 32'h010);
    chk("wr_err",  32'(o_err), 32'd1);
    chk("wr_addr", 32'(fea),   32'd60);
    step();

    // Reset while a send is outstanding with o_req high (257th forward).
    sink_auto = 1'b0;
    send(1, 6'd12, 4'd1);
    wait_grant("rs_grant", 1);
    chk("rs_oreq_hi", 32'(o_req), 32'd1);
    chk("rs_in_send", 32'(dbg),   32'(ST_SEND));
    #2;
    rst_n = 1'b0;
    req   = '0;
    pak   = '0;
    o_ack = 1'b0;
    #1;
    chk("rs_ready", 32'(ready), 32'd0);
    chk("rs_oreq",  32'(o_req), 32'd0);
    chk("rs_ack",   32'(i_ack), 32'd0);
    chk("rs_pak",   32'(o_pak), 32'd0);
    chk("rs_src",   32'(o_src), 32'd0);
    chk("rs_err",   32'(o_err), 32'd0);
    chk("rs_eaddr", 32'(fea),   32'd0);
    chk("rs_esrc",  32'(fes),   32'd0);
    chk("rs_cnt",   32'(o_cnt), 32'd0);
    chk("rs_state", 32'(dbg),   32'(ST_IDLE));
    @(negedge clk);
    rst_n     = 1'b1;
    oreq_seen = 1'b0;
    step();
    chk("rs_rel_ready", 32'(ready), 32'd1);
    send(0, 6'd40, 4'd9);
    wait_grant("rs_fresh", 1);
    chk("rs_fresh_src", 32'(o_src), 32'd0);
    chk("rs_fresh_pak", 32'(o_pak), 32'h289);
    chk("rs_fresh_ack", 32'(i_ack), 32'b0001);
    chk("rs_fresh_cnt", 32'(o_cnt), 32'd1);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
